// File: rtl/rgb_stream_pkg.sv
// Shared encodings for the RGB pixel-stream blocks: pixel-source selects,
// frame-source FSM states and the 24-bit {R,G,B} word packing.
package rgb_stream_pkg;

    localparam logic [1:0] PAT_MEM   = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_RAMP  = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    localparam int RGB_W = 24;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    function automatic logic [RGB_W-1:0] pack_rgb(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
        logic [RGB_W-1:0] w;
        w = '0;
        w[R_LSB +: 8] = r;
        w[G_LSB +: 8] = g;
        w[B_LSB +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/rgb_pattern_gen.sv
// Combinational test-pattern pixel for a given column: colour bars,
// grey ramp or a solid colour. Memory-sourced pixels come out as zero here.
module rgb_pattern_gen
    import rgb_stream_pkg::*;
#(
    parameter int DIM_W     = 12,
    parameter int BAR_SHIFT = 5
) (
    input  logic [DIM_W-1:0] x,
    input  logic [1:0]       pattern_sel,
    input  logic [RGB_W-1:0] const_rgb,
    output logic [RGB_W-1:0] rgb
);

    logic [2:0] bar_idx;

    assign bar_idx = 3'(x >> BAR_SHIFT);

    always_comb begin
        rgb = '0;
        case (pattern_sel)
            // Each channel is on when its index bit is clear: white first, black last.
            PAT_BARS:  rgb = pack_rgb({8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}});
            PAT_RAMP:  rgb = pack_rgb(x[7:0], x[7:0], x[7:0]);
            PAT_SOLID: rgb = const_rgb;
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/rgb_frame_source.sv
// Raster-order RGB pixel-stream source: paced fetches from a synchronous frame
// memory or a built-in pattern, with sof/eol/eof markers and done/busy status.
module rgb_frame_source
    import rgb_stream_pkg::*;
#(
    parameter int DIM_W     = 12,
    parameter int ADDR_W    = 20,
    parameter int GAP       = 1,
    parameter int BAR_SHIFT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  frame_width,
    input  logic [DIM_W-1:0]  frame_height,
    input  logic [1:0]        pattern_sel,
    input  logic [RGB_W-1:0]  const_rgb,
    input  logic [RGB_W-1:0]  mem_rdata,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        r_out,
    output logic [7:0]        g_out,
    output logic [7:0]        b_out,
    output logic              data_valid,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int PACE_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_e             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d, s1_x_q, s1_x_d;
    logic [1:0]         sel_q, sel_d;
    logic [RGB_W-1:0]   const_q, const_d, rgb_q, rgb_d, pat_rgb;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PACE_W-1:0]  pace_q, pace_d;
    logic               rd_q, rd_d, busy_q, busy_d, done_q, done_d, dv_q, dv_d;
    logic               sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic               s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
    logic               s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
    logic               x_last, y_last;

    rgb_pattern_gen #(.DIM_W(DIM_W), .BAR_SHIFT(BAR_SHIFT)) u_pattern (
        .x           (s1_x_q),
        .pattern_sel (sel_q),
        .const_rgb   (const_q),
        .rgb         (pat_rgb)
    );

    assign x_last = (x_q == w_q - DIM_W'(1));
    assign y_last = (y_q == h_q - DIM_W'(1));

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        sel_d    = sel_q;
        const_d  = const_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        pace_d   = pace_q;
        rd_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // x, y and markers ride along with each fetch: fetch -> s1 -> output.
        s1_valid_d = rd_q;
        s1_x_d     = x_q;
        s1_sof_d   = rd_q && (x_q == '0) && (y_q == '0);
        s1_eol_d   = rd_q && x_last;
        s1_eof_d   = rd_q && x_last && y_last;
        dv_d       = s1_valid_q;
        sof_d      = s1_valid_q && s1_sof_q;
        eol_d      = s1_valid_q && s1_eol_q;
        eof_d      = s1_valid_q && s1_eof_q;
        rgb_d      = rgb_q;
        if (s1_valid_q)
            rgb_d = (sel_q == PAT_MEM) ? mem_rdata : pat_rgb;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_d     = frame_width;
                    h_d     = frame_height;
                    sel_d   = pattern_sel;
                    const_d = const_rgb;
                    if (frame_width == '0 || frame_height == '0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        rd_d    = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        pace_d  = '0;
                    end
                end
            end
            ST_RUN: begin
                // Coordinates only change on a fetch, so reaching the last
                // pixel means its fetch is being issued this cycle.
                if (x_last && y_last) begin
                    state_d = ST_DRAIN;
                end else if (pace_q == PACE_W'(GAP)) begin
                    rd_d   = 1'b1;
                    pace_d = '0;
                    addr_d = addr_q + ADDR_W'(1);
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_q + DIM_W'(1);
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                end else begin
                    pace_d = pace_q + PACE_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dv_q && eof_q) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            rd_d       = 1'b0;
            s1_valid_d = 1'b0;
            dv_d       = 1'b0;
            sof_d      = 1'b0;
            eol_d      = 1'b0;
            eof_d      = 1'b0;
            rgb_d      = rgb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            sel_q      <= '0;
            const_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            pace_q     <= '0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            dv_q       <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            sel_q      <= sel_d;
            const_q    <= const_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            pace_q     <= pace_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s1_eof_q   <= s1_eof_d;
            dv_q       <= dv_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            rgb_q      <= rgb_d;
        end
    end

    assign mem_rd_en  = rd_q;
    assign mem_addr   = addr_q;
    assign r_out      = rgb_q[R_LSB +: 8];
    assign g_out      = rgb_q[G_LSB +: 8];
    assign b_out      = rgb_q[B_LSB +: 8];
    assign data_valid = dv_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign eof        = eof_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/rgb_frame_source.md
# rgb_frame_source

Pixel-stream transmitter that drives the `r/g/b + data_valid` interface consumed by the colour point-processing blocks such as the brightness stage. On a `start` pulse it walks a `frame_width × frame_height` frame in raster order. Each pixel comes from an external synchronous-read frame memory or from a built-in test pattern. Every pixel carries frame and line markers, and pixels are paced at a fixed cadence so that bench and on-chip pipelines see the same one-pixel-per-`GAP+1`-cycles stream.

## Interface
- `DIM_W`, 12: width of the frame width and height inputs and of the x/y counters.
- `ADDR_W`, 20: frame-memory word address width.
- `GAP`, 1: idle cycles between consecutive pixels; cadence `P = GAP+1`; 0 gives back-to-back pixels.
- `BAR_SHIFT`, 5: log2 of the colour-bar width in pixels.
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle frame request; honoured only in IDLE.
- `abort`, in, 1: terminates the current frame.
- `frame_width`, in, DIM_W: pixels per line; sampled on an accepted `start`.
- `frame_height`, in, DIM_W: lines per frame; sampled on an accepted `start`.
- `pattern_sel`, in, 2: pixel source; 0 = memory, 1 = colour bars, 2 = grey ramp, 3 = solid colour. Sampled on an accepted `start`.
- `const_rgb`, in, 24: solid colour, R in [23:16], G in [15:8], B in [7:0]; sampled on an accepted `start`.
- `mem_rdata`, in, 24: memory read data in the same packing as `const_rgb`; valid the cycle after `mem_rd_en`.
- `mem_rd_en`, out, 1: memory read strobe.
- `mem_addr`, out, ADDR_W: linear pixel address, `y*frame_width + x`.
- `r_out`, `g_out`, `b_out`, out, 8 each: pixel components.
- `data_valid`, out, 1: pixel qualifier; high for exactly one cycle per pixel.
- `sof`, out, 1: high with the first pixel of a frame.
- `eol`, out, 1: high with the last pixel of each line.
- `eof`, out, 1: high with the last pixel of the frame.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at frame completion.

## Operation
- FSM states are IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - `start=1` latches the frame parameters.
  - If `frame_width==0` or `frame_height==0`, go to FINISH. No pixels are emitted and no memory read is issued.
  - Otherwise go to RUN with `x=y=0`.
- RUN: issues one fetch every P cycles.
  - A fetch drives `mem_rd_en=1` and `mem_addr` equal to the linear address, regardless of `pattern_sel`.
  - The address is kept in an incrementing counter; no multiplier is used.
  - `x` wraps to 0 at `frame_width-1` and `y` then increments.
  - After the fetch of the last pixel, go to DRAIN.
- DRAIN: waits until the last pixel has been presented, then goes to FINISH.
- FINISH: `done=1` for one cycle, then IDLE.
- Pixel sources; x and y travel down the pipeline with each fetch:
  - Memory: `mem_rdata` is unpacked directly to the outputs.
  - Colour bars: with `i = (x >> BAR_SHIFT) & 7`, `R = ~i[1] ? 255 : 0`, `G = ~i[2] ? 255 : 0`, `B = ~i[0] ? 255 : 0`. This gives white, yellow, cyan, green, magenta, red, blue, black.
  - Grey ramp: `R = G = B = x[7:0]`.
  - Solid: the latched `const_rgb`.
- Marker rules:
  - `sof` marks pixel (0,0).
  - `eol` marks every pixel with `x == frame_width-1`.
  - `eof` marks pixel (`frame_width-1`, `frame_height-1`).
  - A 1×1 frame asserts all three markers on its single pixel.
- `start` while busy is ignored.
- Parameter inputs may change freely after they are latched.
- `abort` in RUN or DRAIN:
  - `data_valid`, `mem_rd_en` and all markers are 0 from the next cycle on.
  - Any in-flight pixel is discarded.
  - The FSM goes to IDLE without a `done` pulse.
- `abort` in IDLE is a no-op. `abort` has priority over `start` in the same cycle.

## Timing
- Reset, asynchronous: state IDLE; all outputs 0, including `r/g/b_out`, `mem_addr`, `busy` and `done`.
- Deasserting reset mid-frame leaves the block in IDLE; the frame is not resumed.
- `start` is sampled at edge C0.
  - First `mem_rd_en` is in cycle C1.
  - Fetch k occurs in cycle C1 + k·P.
  - Pixel k is presented (registered `data_valid` and data) in cycle C3 + k·P. Fetch-to-valid latency is 2 cycles for every source.
- `done` occurs in the cycle after the last `data_valid`; `busy` falls in that same `done` cycle.
- Zero-size frame: `done` occurs in C1.
- `r/g/b_out` hold their last value while `data_valid=0`.

## Structure
- Shared package `rgb_stream_pkg` holds:
  - the `pattern_sel` encodings (`PAT_MEM`, `PAT_BARS`, `PAT_RAMP`, `PAT_SOLID`);
  - the FSM state enum;
  - the 24-bit RGB packing constants.
- One sub-module, `rgb_pattern_gen`, provides the combinational pattern pixel from (x, `pattern_sel`, `const_rgb`).
- The FSM, counters and output registers stay in the top module.

## Test plan
- Memory, 4×2 frame, `GAP=1`, model returns `{addr,addr,addr}`:
  - 8 fetches at addresses 0–7, two cycles apart.
  - Pixel k has R=G=B=k.
  - `sof` on k=0; `eol` on k=3 and k=7; `eof` on k=7.
  - `done` the cycle after k=7; first `data_valid` exactly 3 cycles after `start`.
- Colour bars, 256×1, `BAR_SHIFT=5`: x=0 gives (255,255,255), x=32 gives (255,255,0), x=160 gives (255,0,0), x=255 gives (0,0,0).
- Ramp 300×1 gives x=299 as (43,43,43). Solid with `const_rgb=0x123456` gives every pixel as (0x12,0x34,0x56).
- Zero-size frames: `frame_width=0` gives `done` at C1, no `data_valid`, no `mem_rd_en`. 1×1 gives one pixel with `sof`, `eol` and `eof` all high.
- Start and abort handling:
  - Second `start` mid-frame is ignored, and the pixel count stays at W×H.
  - `abort` after pixel 2 of 4×4 gives no further `data_valid`, no `done`; a new `start` then runs a full frame from address 0.
- Asserting `rst_n=0` mid-frame zeroes all outputs immediately. After release, `start` yields a correct full frame.
